// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer slice:
// arbitration mode constants and the channel-index width helper.
package rr_mux_pkg;

    // Arbitration modes selectable through the MODE parameter.
    localparam int RR_MODE_RR    = 0;
    localparam int RR_MODE_FIXED = 1;

    // Number of bits needed to encode a channel index; a 1-channel or
    // 2-channel mux still needs a 1-bit index field.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// Stream bundle between N_CH producers, the multiplexer and one consumer.
// The slave modport is the multiplexer's view (takes the input streams,
// drives the merged output stream); master is the surrounding environment.
interface rr_stream_mux_if
    import rr_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8
);
    localparam int CH_W = clog2_min1(N_CH);

    // Per-channel input streams; channel i data is in_data[i*DATA_W +: DATA_W].
    logic [N_CH-1:0]        in_valid;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_last;
    logic [N_CH-1:0]        in_ready;

    // Merged output stream tagged with the source channel.
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [CH_W-1:0]        out_ch;
    logic                   out_last;
    logic                   out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_last
    );

endinterface

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational arbiter for rr_stream_mux. In round-robin mode the search
// starts at ptr and wraps to channel 0; in fixed mode the lowest requesting
// index wins. Produces a one-hot grant plus its encoded index.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int  N_CH = 4,
    localparam int CH_W = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            fixed,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] idx
);

    logic [N_CH-1:0] hi_mask;
    logic [N_CH-1:0] masked;
    logic [N_CH-1:0] pick;

    // Requests at or above the pointer get first chance; if none exist the
    // search wraps around to the full request vector from channel 0.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N_CH; i++) begin
            hi_mask[i] = fixed ? 1'b1 : (i >= int'(ptr));
        end
        masked = req & hi_mask;
        pick   = (|masked) ? masked : req;
    end

    // Lowest set bit of the candidate vector becomes the one-hot grant.
    always_comb begin
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && pick[i]) begin
                grant[i] = 1'b1;
                idx      = CH_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel streaming multiplexer: arbitrates between requesting channels
// (round-robin or fixed priority), forwards one beat per cycle through a
// single output register and tags it with its source channel index.
// Optional build macro RR_MUX_PKT_LOCK_EN: once a beat without in_last is
// forwarded, the grant stays on that channel until its in_last beat.
module rr_stream_mux
    import rr_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int MODE   = RR_MODE_RR
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_stream_mux_if.slave  bus
);

    localparam int   CH_W  = clog2_min1(N_CH);
    localparam logic FIXED = (MODE == RR_MODE_FIXED);

    logic [CH_W-1:0]   ptr;
    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   grant;
    logic [CH_W-1:0]   gnt_idx;
    logic              take;
    logic              load;
    logic              adv;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;

    // Output register stage
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [CH_W-1:0]   ch_p1;
    logic              last_p1;

`ifdef RR_MUX_PKT_LOCK_EN
    logic              locked;
    logic [CH_W-1:0]   lock_ch;

    // While a packet is open only its owner may request.
    always_comb begin
        req = bus.in_valid;
        if (locked) begin
            req = bus.in_valid & (N_CH'(1) << lock_ch);
        end
    end

    // The pointer moves only when a packet closes, so the owner keeps its
    // round-robin position for the whole packet.
    assign adv = load && sel_last;

    // Lock opens on a non-last beat and closes on the owner's last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (load) begin
            locked  <= !sel_last;
            lock_ch <= gnt_idx;
        end
    end
`else
    assign req = bus.in_valid;
    assign adv = load;
`endif

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .fixed (FIXED),
        .grant (grant),
        .idx   (gnt_idx)
    );

    // The register can take a new beat when empty or being drained this cycle.
    assign take = !vld_p1 || bus.out_ready;
    assign load = (|grant) && take;

    // Accept is suppressed during reset so producers never see a handshake
    // that the cleared output register would discard.
    assign bus.in_ready = rst_n ? (grant & {N_CH{take}}) : '0;

    // One-hot AND-OR mux of the granted channel's payload and last flag.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | bus.in_data[i*DATA_W +: DATA_W];
                sel_last = sel_last | bus.in_last[i];
            end
        end
    end

    // Output register: load replaces the beat (no bubble on drain+load),
    // a drain without load only clears valid and holds the payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
            last_p1 <= 1'b0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= sel_data;
            ch_p1   <= gnt_idx;
            last_p1 <= sel_last;
        end else if (vld_p1 && bus.out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    // Round-robin pointer: next search starts just past the last winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (MODE == RR_MODE_RR && adv) begin
            ptr <= (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + CH_W'(1);
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_ch    = ch_p1;
    assign bus.out_last  = last_p1;

endmodule
